// File: rtl/barrel_pkg.sv
// ---------------------------------------------------------------------------
// barrel_pkg -- shared definitions for the barrel_pipe pipelined shifter.
//   BARREL_WIDTH    : default datapath width
//   BARREL_SHIFT_W  : shift-amount width / pipeline depth for the default width
//   barrel_op_t     : operation encoding (SLL, SRL, SRA, ROR)
//   barrel_shift_w(): derives the shift-amount width from a data width
// ---------------------------------------------------------------------------
package barrel_pkg;

    localparam int BARREL_WIDTH = 32;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } barrel_op_t;

    function automatic int barrel_shift_w(input int width);
        return $clog2(width);
    endfunction

    localparam int BARREL_SHIFT_W = barrel_shift_w(BARREL_WIDTH);

endpackage

// File: rtl/barrel_pipe_shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage -- one level of the logarithmic shifter plus its pipeline
// register. Shifts by 2**STAGE when amt[STAGE] is set, otherwise passes the
// data through. Valid, op and the remaining amount bits travel alongside.
// Optional feature macro: BARREL_ROTATE_EN (op ROR rotates right; without it
// ROR behaves as SRL and no rotate logic is built).
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   en               : register load enable (low while the pipe is stalled)
//   in_valid/in_data/in_op/in_amt     : stage inputs from previous level
//   out_valid/out_data/out_op/out_amt : registered stage outputs
// ---------------------------------------------------------------------------
module shift_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH   = BARREL_WIDTH,
    parameter int SHIFT_W = barrel_shift_w(WIDTH),
    parameter int STAGE   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  barrel_op_t         in_op,
    input  logic [SHIFT_W-1:0] in_amt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output barrel_op_t         out_op,
    output logic [SHIFT_W-1:0] out_amt
);

    localparam int SH = 2 ** STAGE;

    logic               valid_d, valid_q;
    logic [WIDTH-1:0]   data_d, data_q;
    barrel_op_t         op_d, op_q;
    logic [SHIFT_W-1:0] amt_d, amt_q;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        shifted = {{SH{1'b0}}, in_data[WIDTH-1:SH]};
        unique case (in_op)
            SLL: shifted = {in_data[WIDTH-1-SH:0], {SH{1'b0}}};
            SRL: shifted = {{SH{1'b0}}, in_data[WIDTH-1:SH]};
            // The MSB still holds the original sign bit at every level,
            // because earlier SRA levels replicate it.
            SRA: shifted = {{SH{in_data[WIDTH-1]}}, in_data[WIDTH-1:SH]};
`ifdef BARREL_ROTATE_EN
            ROR: shifted = {in_data[SH-1:0], in_data[WIDTH-1:SH]};
`else
            ROR: shifted = {{SH{1'b0}}, in_data[WIDTH-1:SH]};
`endif
            default: shifted = in_data;
        endcase
    end

    always_comb begin
        valid_d       = in_valid;
        op_d          = in_op;
        data_d        = in_amt[STAGE] ? shifted : in_data;
        amt_d         = in_amt;
        amt_d[STAGE]  = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= SLL;
            amt_q   <= '0;
        end else if (en) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_op    = op_q;
    assign out_amt   = amt_q;

endmodule

// File: rtl/barrel_pipe.sv
// ---------------------------------------------------------------------------
// barrel_pipe -- pipelined logarithmic shifter/rotator with valid/ready flow
// control. SHIFT_W registered levels; a result appears SHIFT_W cycles after
// acceptance when unstalled. A stalled output freezes the whole pipe.
// Optional feature macro: BARREL_ROTATE_EN (op 11 = rotate right; otherwise
// op 11 is a logical right shift).
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid, in_ready  : input handshake
//   in_data, in_amt     : operand and shift/rotate amount
//   in_op               : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid, out_ready: output handshake
//   out_data            : result
// ---------------------------------------------------------------------------
module barrel_pipe
    import barrel_pkg::*;
#(
    parameter  int WIDTH   = BARREL_WIDTH,
    localparam int SHIFT_W = barrel_shift_w(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHIFT_W-1:0] in_amt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    // Index 0 is the pipe input; index k+1 is the register of level k.
    logic [SHIFT_W:0]   valid_s;
    logic [WIDTH-1:0]   data_s [SHIFT_W+1];
    barrel_op_t         op_s   [SHIFT_W+1];
    logic [SHIFT_W-1:0] amt_s  [SHIFT_W+1];
    logic               stall;
    logic               unused_tail;

    assign stall      = valid_s[SHIFT_W] && !out_ready;
    assign in_ready   = !stall;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_data;
    assign op_s[0]    = barrel_op_t'(in_op);
    assign amt_s[0]   = in_amt;

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH   (WIDTH),
            .SHIFT_W (SHIFT_W),
            .STAGE   (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (!stall),
            .in_valid  (valid_s[k]),
            .in_data   (data_s[k]),
            .in_op     (op_s[k]),
            .in_amt    (amt_s[k]),
            .out_valid (valid_s[k+1]),
            .out_data  (data_s[k+1]),
            .out_op    (op_s[k+1]),
            .out_amt   (amt_s[k+1])
        );
    end

    assign out_valid   = valid_s[SHIFT_W];
    assign out_data    = data_s[SHIFT_W];

    // Op and amount are fully consumed by the last level.
    assign unused_tail = ^{op_s[SHIFT_W], amt_s[SHIFT_W]};

endmodule

// File: tb/tb_barrel_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_pipe -- self-checking bench for barrel_pipe (default WIDTH=32).
// Honours BARREL_ROTATE_EN for the expected op-11 behaviour.
// ---------------------------------------------------------------------------
module tb_barrel_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [4:0]    in_amt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q [$];

    barrel_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Whole-word reference: result of the complete operation in one step.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input logic [4:0] a,
                                               input logic [1:0] op);
        logic [63:0] dbl;
        case (op)
            2'b00: return d << a;
            2'b01: return d >> a;
            2'b10: return $unsigned($signed(d) >>> a);
            default: begin
`ifdef BARREL_ROTATE_EN
                dbl = {d, d} >> a;
                return dbl[W-1:0];
`else
                dbl = '0;
                return (d >> a) | dbl[W-1:0];
`endif
            end
        endcase
    endfunction

    // Single unstalled operation: checks acceptance, 5-cycle latency, result.
    task automatic run_one(input logic [1:0] op, input logic [W-1:0] d, input logic [4:0] a,
                           input logic [W-1:0] exp, input string tag, input bit release_rst);
        int lat;
        @(negedge clk);
        if (release_rst) reset = 1'b0;
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        in_amt    = a;
        out_ready = 1'b1;
        #1 check({tag, "_ready"}, W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, W'(lat), W'(5));
        check({tag, "_data"}, out_data, exp);
    endtask

    // mode 0: out_ready high; 1: out_ready low in cycles 6-8; 2: random both sides.
    task automatic run_stream(input int n, input int mode, input string tag);
        logic [W-1:0] d;
        logic [4:0]   a;
        logic [1:0]   o;
        logic         in_fire, out_fire, prev_stall;
        logic [W-1:0] prev_data;
        int issued, got, cyc;
        issued     = 0;
        got        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        exp_q.delete();
        d = $urandom; a = 5'($urandom); o = 2'($urandom);
        while ((issued < n || got < n) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (issued < n) && (mode != 2 || $urandom_range(0, 3) != 0);
            in_data   = d;
            in_amt    = a;
            in_op     = o;
            out_ready = (mode == 2) ? ($urandom_range(0, 9) < 7) : !(mode == 1 && cyc >= 6 && cyc <= 8);
            #1;
            if (mode == 1 && cyc <= 10)
                check({tag, "_in_ready"}, W'(in_ready), (cyc >= 6 && cyc <= 8) ? W'(0) : W'(1));
            if (prev_stall)
                check({tag, "_hold"}, out_data, prev_data);
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_spurious"}, W'(out_valid), W'(0));
                end else begin
                    check({tag, "_data"}, out_data, exp_q.pop_front());
                    got++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_fire) begin
                exp_q.push_back(ref_model(d, a, o));
                issued++;
                d = $urandom; a = 5'($urandom); o = 2'($urandom);
            end
        end
        check({tag, "_count"}, W'(got), W'(n));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int vcount;
        logic [W-1:0] ror_exp;
        logic [1:0]   op_v;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));

        // First op presented on the very cycle reset is released.
        run_one(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll31", 1'b1);
        run_one(2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, "sra4", 1'b0);
        run_one(2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, "srl4", 1'b0);
`ifdef BARREL_ROTATE_EN
        ror_exp = 32'h8000_0000;
`else
        ror_exp = 32'h0000_0000;
`endif
        run_one(2'b11, 32'h0000_0001, 5'd1, ror_exp, "op11_amt1", 1'b0);
        for (int i = 0; i < 4; i++) begin
            op_v = 2'(i);
            run_one(op_v, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5, $sformatf("amt0_op%0d", i), 1'b0);
        end

        run_stream(8, 1, "b2b_stall");

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            in_amt   = 5'($urandom);
            in_op    = 2'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_data", out_data, W'(0));
        repeat (2) @(negedge clk);
        run_one(2'b10, 32'h4000_0000, 5'd2, 32'h1000_0000, "post_rst", 1'b1);
        @(negedge clk);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) vcount++;
        end
        check("no_stale", W'(vcount), W'(0));

        run_stream(40, 0, "rand_full");
        run_stream(300, 2, "rand_bp");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
